// File: rtl/ysyx_22050368_wbck_arbiter_pkg.sv
// ============================================================================
// ysyx_22050368_wbck_arbiter_pkg : shared widths for the writeback arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package ysyx_22050368_wbck_arbiter_pkg;
  localparam int XLEN        = 64;
  localparam int RFIDX_WIDTH = 5;
  localparam int RFREG_NUM   = 32;

  function automatic logic [RFREG_NUM-1:0] idx_onehot(input logic [RFIDX_WIDTH-1:0] idx);
    idx_onehot      = '0;
    idx_onehot[idx] = 1'b1;
  endfunction
endpackage

`default_nettype wire

// File: rtl/ysyx_22050368_wbck_arbiter_if.sv
// ============================================================================
// ysyx_22050368_wbck_arbiter_if : requester, dispatch and regfile-write bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface ysyx_22050368_wbck_arbiter_if;
  import ysyx_22050368_wbck_arbiter_pkg::*;

  logic                   alu_wbck_valid;
  logic                   alu_wbck_ready;
  logic [RFIDX_WIDTH-1:0] alu_wbck_idx;
  logic [XLEN-1:0]        alu_wbck_dat;
  logic                   lsu_wbck_valid;
  logic                   lsu_wbck_ready;
  logic [RFIDX_WIDTH-1:0] lsu_wbck_idx;
  logic [XLEN-1:0]        lsu_wbck_dat;
  logic                   disp_set_en;
  logic [RFIDX_WIDTH-1:0] disp_set_idx;
  logic [RFIDX_WIDTH-1:0] disp_rs1_idx;
  logic [RFIDX_WIDTH-1:0] disp_rs2_idx;
  logic [RFIDX_WIDTH-1:0] disp_rd_idx;
  logic                   disp_hazard;
  logic                   wbck_dest_wen;
  logic [RFIDX_WIDTH-1:0] wbck_dest_idx;
  logic [XLEN-1:0]        wbck_dest_dat;

  modport master (
    output alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
    output lsu_wbck_valid, lsu_wbck_idx, lsu_wbck_dat,
    output disp_set_en, disp_set_idx, disp_rs1_idx, disp_rs2_idx, disp_rd_idx,
    input  alu_wbck_ready, lsu_wbck_ready, disp_hazard,
    input  wbck_dest_wen, wbck_dest_idx, wbck_dest_dat
  );

  modport slave (
    input  alu_wbck_valid, alu_wbck_idx, alu_wbck_dat,
    input  lsu_wbck_valid, lsu_wbck_idx, lsu_wbck_dat,
    input  disp_set_en, disp_set_idx, disp_rs1_idx, disp_rs2_idx, disp_rd_idx,
    output alu_wbck_ready, lsu_wbck_ready, disp_hazard,
    output wbck_dest_wen, wbck_dest_idx, wbck_dest_dat
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_22050368_wbck_scoreboard.sv
// ============================================================================
// ysyx_22050368_wbck_scoreboard : per-register pending bits and hazard lookup
// Rev 1.0
// ============================================================================
`default_nettype none

module ysyx_22050368_wbck_scoreboard
  import ysyx_22050368_wbck_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [RFIDX_WIDTH-1:0] set_idx,
  input  logic                   clr_en,
  input  logic [RFIDX_WIDTH-1:0] clr_idx,
  input  logic [RFIDX_WIDTH-1:0] rs1_idx,
  input  logic [RFIDX_WIDTH-1:0] rs2_idx,
  input  logic [RFIDX_WIDTH-1:0] rd_idx,
  output logic                   hazard
);
  logic [RFREG_NUM-1:0] pending;
  logic [RFREG_NUM-1:0] pending_nxt;
  logic [RFREG_NUM-1:0] set_mask;
  logic [RFREG_NUM-1:0] clr_mask;

  assign set_mask = set_en ? idx_onehot(set_idx) : '0;
  assign clr_mask = clr_en ? idx_onehot(clr_idx) : '0;

  // Set is applied after clear so a same-cycle dispatch keeps the register busy.
  always_comb begin
    pending_nxt    = (pending & ~clr_mask) | set_mask;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  assign hazard = pending[rs1_idx] | pending[rs2_idx] | pending[rd_idx];
endmodule

`default_nettype wire

// File: rtl/ysyx_22050368_wbck_arbiter.sv
// ============================================================================
// ysyx_22050368_wbck_arbiter : ALU/LSU writeback arbitration onto one regfile port
// Rev 1.0
// ============================================================================
`default_nettype none

module ysyx_22050368_wbck_arbiter
  import ysyx_22050368_wbck_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_22050368_wbck_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic                   alu_grant;
  logic                   lsu_grant;
  logic                   any_grant;
  logic                   starved;
  logic [CNT_W-1:0]       starve_cnt;
  logic [RFIDX_WIDTH-1:0] grant_idx;
  logic [XLEN-1:0]        grant_dat;
  logic                   wen_q;
  logic [RFIDX_WIDTH-1:0] idx_q;
  logic [XLEN-1:0]        dat_q;

  // LSU has priority, except when the ALU has lost STARVE_MAX times in a row.
  assign starved   = (starve_cnt == CNT_W'(STARVE_MAX));
  assign alu_grant = bus.alu_wbck_valid & (~bus.lsu_wbck_valid | starved);
  assign lsu_grant = bus.lsu_wbck_valid & ~alu_grant;
  assign any_grant = alu_grant | lsu_grant;
  assign grant_idx = alu_grant ? bus.alu_wbck_idx : bus.lsu_wbck_idx;
  assign grant_dat = alu_grant ? bus.alu_wbck_dat : bus.lsu_wbck_dat;

  assign bus.alu_wbck_ready = alu_grant;
  assign bus.lsu_wbck_ready = lsu_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!bus.alu_wbck_valid || alu_grant) begin
      starve_cnt <= '0;
    end else if (lsu_grant && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // x0 writes are consumed but never reach the regfile.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q <= 1'b0;
      idx_q <= '0;
      dat_q <= '0;
    end else begin
      wen_q <= any_grant & (grant_idx != '0);
      if (any_grant) begin
        idx_q <= grant_idx;
        dat_q <= grant_dat;
      end
    end
  end

  assign bus.wbck_dest_wen = wen_q;
  assign bus.wbck_dest_idx = idx_q;
  assign bus.wbck_dest_dat = dat_q;

  ysyx_22050368_wbck_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (bus.disp_set_en),
    .set_idx (bus.disp_set_idx),
    .clr_en  (wen_q),
    .clr_idx (idx_q),
    .rs1_idx (bus.disp_rs1_idx),
    .rs2_idx (bus.disp_rs2_idx),
    .rd_idx  (bus.disp_rd_idx),
    .hazard  (bus.disp_hazard)
  );
endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050368_wbck_arbiter.sv
// ============================================================================
// tb_ysyx_22050368_wbck_arbiter : directed self-checking bench for the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_22050368_wbck_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  ysyx_22050368_wbck_arbiter_if bus ();

  ysyx_22050368_wbck_arbiter #(.STARVE_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Inputs change 1 time unit after the rising edge; outputs are read a unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_wbck_valid = 1'b0; bus.alu_wbck_idx = '0; bus.alu_wbck_dat = '0;
    bus.lsu_wbck_valid = 1'b0; bus.lsu_wbck_idx = '0; bus.lsu_wbck_dat = '0;
    bus.disp_set_en    = 1'b0; bus.disp_set_idx = '0;
    bus.disp_rs1_idx   = '0;   bus.disp_rs2_idx = '0; bus.disp_rd_idx = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    bus.disp_rs1_idx = 5'd5;
    #1;
    total_cnt++;
    if (bus.wbck_dest_wen !== 1'b0) $display("FAIL reset_wen got=%b exp=0", bus.wbck_dest_wen);
    else pass_cnt++;
    total_cnt++;
    if (bus.wbck_dest_idx !== 5'd0) $display("FAIL reset_idx got=%0d exp=0", bus.wbck_dest_idx);
    else pass_cnt++;
    total_cnt++;
    if (bus.wbck_dest_dat !== 64'd0) $display("FAIL reset_dat got=%h exp=0", bus.wbck_dest_dat);
    else pass_cnt++;
    total_cnt++;
    if (bus.disp_hazard !== 1'b0) $display("FAIL reset_hazard got=%b exp=0", bus.disp_hazard);
    else pass_cnt++;
    bus.disp_rs1_idx = '0;
  endtask

  task automatic test_alu_single();
    bus.alu_wbck_valid = 1'b1; bus.alu_wbck_idx = 5'd5; bus.alu_wbck_dat = 64'hAA;
    #1;
    total_cnt++;
    if (bus.alu_wbck_ready !== 1'b1 || bus.lsu_wbck_ready !== 1'b0)
      $display("FAIL alu_only_ready got=%b%b exp=10", bus.alu_wbck_ready, bus.lsu_wbck_ready);
    else pass_cnt++;
    tick();
    bus.alu_wbck_valid = 1'b0;
    #1;
    total_cnt++;
    if (bus.wbck_dest_wen !== 1'b1 || bus.wbck_dest_idx !== 5'd5 || bus.wbck_dest_dat !== 64'hAA)
      $display("FAIL alu_only_write got=%b/%0d/%h exp=1/5/aa",
               bus.wbck_dest_wen, bus.wbck_dest_idx, bus.wbck_dest_dat);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.wbck_dest_wen !== 1'b0) $display("FAIL alu_only_wen_drop got=%b exp=0", bus.wbck_dest_wen);
    else pass_cnt++;
  endtask

  task automatic test_lsu_single();
    bus.lsu_wbck_valid = 1'b1; bus.lsu_wbck_idx = 5'd6; bus.lsu_wbck_dat = 64'h1234_5678_9ABC_DEF0;
    #1;
    total_cnt++;
    if (bus.alu_wbck_ready !== 1'b0 || bus.lsu_wbck_ready !== 1'b1)
      $display("FAIL lsu_only_ready got=%b%b exp=01", bus.alu_wbck_ready, bus.lsu_wbck_ready);
    else pass_cnt++;
    tick();
    bus.lsu_wbck_valid = 1'b0;
    #1;
    total_cnt++;
    if (bus.wbck_dest_wen !== 1'b1 || bus.wbck_dest_idx !== 5'd6 ||
        bus.wbck_dest_dat !== 64'h1234_5678_9ABC_DEF0)
      $display("FAIL lsu_only_write got=%b/%0d/%h exp=1/6/123456789abcdef0",
               bus.wbck_dest_wen, bus.wbck_dest_idx, bus.wbck_dest_dat);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_starvation();
    logic exp_alu;
    bus.alu_wbck_valid = 1'b1; bus.alu_wbck_idx = 5'd1; bus.alu_wbck_dat = 64'h11;
    bus.lsu_wbck_valid = 1'b1; bus.lsu_wbck_idx = 5'd2; bus.lsu_wbck_dat = 64'h22;
    for (int c = 0; c < 8; c++) begin
      exp_alu = ((c % 4) == 3);
      #1;
      total_cnt++;
      if (bus.alu_wbck_ready !== exp_alu || bus.lsu_wbck_ready !== !exp_alu)
        $display("FAIL starve_grant cycle=%0d got=%b%b exp=%b%b",
                 c, bus.alu_wbck_ready, bus.lsu_wbck_ready, exp_alu, !exp_alu);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.wbck_dest_idx !== (exp_alu ? 5'd1 : 5'd2) || bus.wbck_dest_wen !== 1'b1)
        $display("FAIL starve_write cycle=%0d got=%b/%0d exp=1/%0d",
                 c, bus.wbck_dest_wen, bus.wbck_dest_idx, exp_alu ? 1 : 2);
      else pass_cnt++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_hazard_clear();
    bus.disp_set_en = 1'b1; bus.disp_set_idx = 5'd7;
    tick();
    bus.disp_set_en = 1'b0; bus.disp_rs1_idx = 5'd7;
    #1;
    total_cnt++;
    if (bus.disp_hazard !== 1'b1) $display("FAIL hazard_rs1_set got=%b exp=1", bus.disp_hazard);
    else pass_cnt++;
    bus.alu_wbck_valid = 1'b1; bus.alu_wbck_idx = 5'd7; bus.alu_wbck_dat = 64'h77;
    tick();
    bus.alu_wbck_valid = 1'b0;
    #1;
    total_cnt++;
    if (bus.wbck_dest_wen !== 1'b1 || bus.disp_hazard !== 1'b1)
      $display("FAIL hazard_during_wen got=%b/%b exp=1/1", bus.wbck_dest_wen, bus.disp_hazard);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.disp_hazard !== 1'b0) $display("FAIL hazard_cleared got=%b exp=0", bus.disp_hazard);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_set_wins();
    bus.disp_set_en = 1'b1; bus.disp_set_idx = 5'd9;
    tick();
    bus.disp_set_en = 1'b0;
    bus.alu_wbck_valid = 1'b1; bus.alu_wbck_idx = 5'd9; bus.alu_wbck_dat = 64'h99;
    tick();
    bus.alu_wbck_valid = 1'b0;
    bus.disp_set_en = 1'b1; bus.disp_set_idx = 5'd9; bus.disp_rd_idx = 5'd9;
    #1;
    total_cnt++;
    if (bus.wbck_dest_wen !== 1'b1 || bus.wbck_dest_idx !== 5'd9)
      $display("FAIL set_wins_wen got=%b/%0d exp=1/9", bus.wbck_dest_wen, bus.wbck_dest_idx);
    else pass_cnt++;
    tick();
    bus.disp_set_en = 1'b0;
    #1;
    total_cnt++;
    if (bus.disp_hazard !== 1'b1) $display("FAIL set_wins_rd got=%b exp=1", bus.disp_hazard);
    else pass_cnt++;
    bus.disp_rd_idx = 5'd0; bus.disp_rs2_idx = 5'd9;
    #1;
    total_cnt++;
    if (bus.disp_hazard !== 1'b1) $display("FAIL set_wins_rs2 got=%b exp=1", bus.disp_hazard);
    else pass_cnt++;
    bus.lsu_wbck_valid = 1'b1; bus.lsu_wbck_idx = 5'd9; bus.lsu_wbck_dat = 64'h9;
    tick();
    bus.lsu_wbck_valid = 1'b0;
    tick();
    total_cnt++;
    if (bus.disp_hazard !== 1'b0) $display("FAIL set_wins_final_clear got=%b exp=0", bus.disp_hazard);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_idx_zero();
    bus.alu_wbck_valid = 1'b1; bus.alu_wbck_idx = 5'd0; bus.alu_wbck_dat = 64'h55;
    #1;
    total_cnt++;
    if (bus.alu_wbck_ready !== 1'b1) $display("FAIL x0_ready got=%b exp=1", bus.alu_wbck_ready);
    else pass_cnt++;
    tick();
    bus.alu_wbck_valid = 1'b0;
    bus.disp_set_en = 1'b1; bus.disp_set_idx = 5'd0; bus.disp_rs1_idx = 5'd0;
    #1;
    total_cnt++;
    if (bus.wbck_dest_wen !== 1'b0 || bus.wbck_dest_idx !== 5'd0 || bus.wbck_dest_dat !== 64'h55)
      $display("FAIL x0_write got=%b/%0d/%h exp=0/0/55",
               bus.wbck_dest_wen, bus.wbck_dest_idx, bus.wbck_dest_dat);
    else pass_cnt++;
    tick();
    bus.disp_set_en = 1'b0;
    #1;
    total_cnt++;
    if (bus.disp_hazard !== 1'b0) $display("FAIL x0_hazard got=%b exp=0", bus.disp_hazard);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    bus.disp_set_en = 1'b1; bus.disp_set_idx = 5'd3;
    tick();
    bus.disp_set_en = 1'b0; bus.disp_rs1_idx = 5'd3;
    #1;
    total_cnt++;
    if (bus.disp_hazard !== 1'b1) $display("FAIL midrst_pending got=%b exp=1", bus.disp_hazard);
    else pass_cnt++;
    bus.alu_wbck_valid = 1'b1; bus.alu_wbck_idx = 5'd4; bus.alu_wbck_dat = 64'h44;
    tick();
    bus.alu_wbck_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total_cnt++;
    if (bus.wbck_dest_wen !== 1'b0 || bus.wbck_dest_idx !== 5'd0 || bus.wbck_dest_dat !== 64'd0)
      $display("FAIL midrst_outputs got=%b/%0d/%h exp=0/0/0",
               bus.wbck_dest_wen, bus.wbck_dest_idx, bus.wbck_dest_dat);
    else pass_cnt++;
    total_cnt++;
    if (bus.disp_hazard !== 1'b0) $display("FAIL midrst_hazard got=%b exp=0", bus.disp_hazard);
    else pass_cnt++;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_alu_single();
    test_lsu_single();
    test_starvation();
    test_hazard_clear();
    test_set_wins();
    test_idx_zero();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

`default_nettype wire
